bank_write_scheduler: RTL and testbench
=======================================

Name: bank_write_scheduler

Overview:
Schedules writes from REQ_COUNT parallel product/accumulator requesters into a BANK_COUNT-banked tile buffer. Each request carries a (row, column) tile coordinate. The block maps each coordinate to a (bank, entry) pair using the team's bitwidth-dependent bank mapping, then arbitrates so each bank takes at most one write per cycle. It sits between the multiplier-array output crossbar and the banked accumulator/output SRAMs.

Parameters:
BANK_COUNT, 32, number of banks (power of two)
TILE_SIZE, 256, rows/columns per tile (power of two); RW = $clog2(TILE_SIZE)
REQ_COUNT, 4, number of requesters
DATA_WIDTH, 16, write data width
CNT_WIDTH, 16, conflict counter width

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
cfg_load  input  1  load cfg_bitwidth into the active bitwidth register
cfg_bitwidth  input  2  precision mode 0..3
req_valid  input  REQ_COUNT  request valid, one bit per requester
req_row  input  REQ_COUNT*RW  row per requester (requester i at bits [i*RW +: RW])
req_column  input  REQ_COUNT*RW  column per requester
req_data  input  REQ_COUNT*DATA_WIDTH  write data per requester
req_ready  output  REQ_COUNT  grant; transfer occurs when valid & ready
bank_we  output  BANK_COUNT  registered write enable per bank
bank_entry  output  BANK_COUNT*RW  registered entry address per bank
bank_data  output  BANK_COUNT*DATA_WIDTH  registered write data per bank
conflict_count  output  CNT_WIDTH  saturating count of cycles with at least one denied valid request
busy  output  1  high when any req_valid is high or any bank_we is high

Behaviour:
- Mapping (bw = active bitwidth register):
  - upper = row >> bw
  - section = row mod 2^bw
  - bank = (column + 3*upper + section*(BANK_COUNT >> bw)) mod BANK_COUNT
  - entry = row >> bw
  - Compute the mapping in full precision, then truncate to $clog2(BANK_COUNT) bits.
- Arbitration is combinational within the cycle.
  - Priority order is ptr, ptr+1, ..., ptr+REQ_COUNT-1 (mod REQ_COUNT).
  - A valid requester is granted if no higher-priority valid requester maps to the same bank.
  - req_ready[i] = granted[i].
  - req_ready[i] is 0 whenever req_valid[i] is 0.
  - req_ready never depends on the data fields except through the bank mapping.
- Requesters hold row, column and data stable until granted. The block holds no request storage.
- Output register: on the clock edge after a grant to requester i targeting bank b:
  - bank_we[b] = 1
  - bank_entry[b] = entry_i
  - bank_data[b] = req_data_i
  - Banks without a grant have bank_we = 0; their entry and data fields hold the previous values.
- Latency: exactly 1 cycle from grant to bank_we.
- Pointer update:
  - If at least one valid request is denied in a cycle, ptr <= (ptr+1) mod REQ_COUNT.
  - Otherwise ptr holds.
  - Guarantees service within REQ_COUNT cycles of contention.
- conflict_count increments by 1 in every cycle with at least one denied valid request and saturates at all-ones.
- Config:
  - cfg_load=1 latches cfg_bitwidth.
  - The new value is used for mapping from the next cycle. The current cycle's arbitration uses the old value, even if requests are valid.
  - Software changes the bitwidth only while busy=0. The block does not enforce this.
- Reset values: bank_we=0, bank_entry=0, bank_data=0, ptr=0, bitwidth=0, conflict_count=0.
- Reset is synchronous and active-high. Reset mid-operation drops any granted-but-unwritten output, i.e. bank_we=0 on the next cycle.
- While reset is high, req_ready=0.
- Edge cases:
  - All requesters hitting distinct banks: all granted in the same cycle.
  - All requesters hitting one bank: one grant per cycle, rotating.
  - REQ_COUNT=1: no conflicts possible; ptr stays 0.

Test Plan:
1. Reset then idle: hold reset 2 cycles with req_valid=4'b1111 -> req_ready=0, bank_we=0, conflict_count=0, busy follows req_valid after reset drops.
2. Distinct banks, bw=0: req0 (r=1,c=0)->bank3/entry1; req1 (r=0,c=5)->bank5/entry0; req2 (r=10,c=0)->bank30/entry10; req3 (r=11,c=0)->bank1/entry11 -> req_ready=4'b1111; next cycle bank_we bits 3,5,30,1 set, entries 1,0,10,11, conflict_count stays 0.
3. Conflict, bw=0: req0 (r=1,c=0) and req1 (r=0,c=3) both map to bank3 -> cycle0 grants req0 only, conflict_count=1, ptr=1; cycle1 grants req1, bank3 entry 0 written with req1 data.
4. Bitwidth mapping: cfg_load with cfg_bitwidth=1, then next cycle req0 (r=5,c=12) -> bank 2, entry 2; same-cycle load with a request uses the bw=0 mapping, i.e. bank 27, entry 5.
5. Fairness: all four requesters target bank 7 continuously -> grants in order req0, req1, req2, req3, one per cycle; conflict_count=3 after the last grant.
6. Reset mid-stream: assert reset in the cycle after a grant -> bank_we=0 next cycle, ptr=0, conflict_count=0.

Source files
------------

// File: rtl/bank_write_scheduler.sv
// Maps requester tile coordinates to (bank, entry) pairs and grants at most one
// write per bank per cycle, using a rotating priority pointer for fairness.
module bank_write_scheduler #(
  parameter int BANK_COUNT = 32,
  parameter int TILE_SIZE  = 256,
  parameter int REQ_COUNT  = 4,
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 16,
  localparam int RW        = $clog2(TILE_SIZE),
  localparam int BANK_W    = $clog2(BANK_COUNT),
  localparam int PTR_W     = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             cfg_load,
  input  logic [1:0]                       cfg_bitwidth,
  input  logic [REQ_COUNT-1:0]             req_valid,
  input  logic [REQ_COUNT*RW-1:0]          req_row,
  input  logic [REQ_COUNT*RW-1:0]          req_column,
  input  logic [REQ_COUNT*DATA_WIDTH-1:0]  req_data,
  output logic [REQ_COUNT-1:0]             req_ready,
  output logic [BANK_COUNT-1:0]            bank_we,
  output logic [BANK_COUNT*RW-1:0]         bank_entry,
  output logic [BANK_COUNT*DATA_WIDTH-1:0] bank_data,
  output logic [CNT_WIDTH-1:0]             conflict_count,
  output logic                             busy
);

  logic [1:0]       bitwidth;
  logic [PTR_W-1:0] ptr;
  logic [BANK_W-1:0] req_bank  [REQ_COUNT];
  logic [RW-1:0]     req_entry [REQ_COUNT];
  int                rank      [REQ_COUNT];
  logic [REQ_COUNT-1:0] grant;
  logic                 denied;

  // Evaluated at 32 bits so the sum never wraps before the final modulo.
  function automatic logic [BANK_W-1:0] map_bank(input logic [RW-1:0] row,
                                                 input logic [RW-1:0] column,
                                                 input logic [1:0]    bw);
    logic [31:0] upper;
    logic [31:0] section;
    logic [31:0] stride;
    logic [31:0] sum;
    upper   = 32'(row) >> bw;
    section = 32'(row) & ((32'd1 << bw) - 32'd1);
    stride  = 32'(BANK_COUNT) >> bw;
    sum     = 32'(column) + 32'd3 * upper + section * stride;
    return sum[BANK_W-1:0];
  endfunction

  always_comb begin
    for (int i = 0; i < REQ_COUNT; i++) begin
      req_bank[i]  = map_bank(req_row[i*RW +: RW], req_column[i*RW +: RW], bitwidth);
      req_entry[i] = req_row[i*RW +: RW] >> bitwidth;
      rank[i]      = (i + REQ_COUNT - int'(ptr)) % REQ_COUNT;
    end
  end

  // NOTE: every bit of grant gets a value before any conditional update, so
  // this block stays purely combinational and no latch is inferred.
  always_comb begin
    grant = '0;
    for (int i = 0; i < REQ_COUNT; i++) begin
      grant[i] = req_valid[i] & ~reset;
      for (int j = 0; j < REQ_COUNT; j++) begin
        if (j != i && req_valid[j] && req_bank[j] == req_bank[i] && rank[j] < rank[i]) begin
          grant[i] = 1'b0;
        end
      end
    end
  end

  assign req_ready = grant;
  assign denied    = |(req_valid & ~grant);
  assign busy      = (|req_valid) | (|bank_we);

  // NOTE: state updates use non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      bitwidth       <= '0;
      ptr            <= '0;
      conflict_count <= '0;
      bank_we        <= '0;
      // NOTE: entry/data are plain output registers, not an SRAM array, so they
      // are cleared on reset to give the sinks a defined starting value.
      bank_entry     <= '0;
      bank_data      <= '0;
    end else begin
      if (cfg_load) begin
        bitwidth <= cfg_bitwidth;
      end

      bank_we <= '0;
      for (int i = 0; i < REQ_COUNT; i++) begin
        if (grant[i]) begin
          bank_we[req_bank[i]]                                <= 1'b1;
          bank_entry[int'(req_bank[i])*RW +: RW]              <= req_entry[i];
          bank_data[int'(req_bank[i])*DATA_WIDTH +: DATA_WIDTH] <= req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end

      // Rotating the pointer only on contention guarantees service within
      // REQ_COUNT cycles while leaving uncontended traffic undisturbed.
      if (denied) begin
        ptr <= (int'(ptr) == REQ_COUNT - 1) ? '0 : ptr + PTR_W'(1);
        if (conflict_count != '1) begin
          conflict_count <= conflict_count + CNT_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_bank_write_scheduler.sv
// Self-checking bench for bank_write_scheduler: directed scenarios plus random
// traffic compared against a queue-free behavioural model of the scheduler.
module tb_bank_write_scheduler;

  localparam int N  = 4;
  localparam int NB = 32;
  localparam int RW = 8;
  localparam int DW = 16;
  localparam int CW = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic            cfg_load;
  logic [1:0]      cfg_bitwidth;
  logic [N-1:0]    req_valid;
  logic [N*RW-1:0] req_row;
  logic [N*RW-1:0] req_column;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic [NB-1:0]   bank_we;
  logic [NB*RW-1:0] bank_entry;
  logic [NB*DW-1:0] bank_data;
  logic [CW-1:0]   conflict_count;
  logic            busy;

  always #5 clk = ~clk;

  bank_write_scheduler #(
    .BANK_COUNT(NB), .TILE_SIZE(256), .REQ_COUNT(N), .DATA_WIDTH(DW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_bitwidth(cfg_bitwidth),
    .req_valid(req_valid), .req_row(req_row), .req_column(req_column),
    .req_data(req_data), .req_ready(req_ready), .bank_we(bank_we),
    .bank_entry(bank_entry), .bank_data(bank_data),
    .conflict_count(conflict_count), .busy(busy)
  );

  int checks   = 0;
  int failures = 0;

  // Requester-side state: each requester holds its request until granted.
  logic [N-1:0]  v_valid;
  logic [RW-1:0] v_row  [N];
  logic [RW-1:0] v_col  [N];
  logic [DW-1:0] v_data [N];

  // Reference model state.
  int            m_ptr;
  int            m_bw;
  int            m_cnt;
  logic [NB-1:0] m_we;
  logic [RW-1:0] m_entry [NB];
  logic [DW-1:0] m_data  [NB];

  logic [N-1:0]  exp_ready;
  logic [N-1:0]  obs_ready;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_bank(input int row, input int col, input int bw);
    return (col + 3 * (row >> bw) + (row % (1 << bw)) * (NB >> bw)) % NB;
  endfunction

  // Walk requesters in priority order; the first to claim a bank wins it.
  function automatic logic [N-1:0] model_grant();
    bit           taken [NB];
    logic [N-1:0] g;
    int           r;
    int           b;
    g = '0;
    foreach (taken[k]) taken[k] = 1'b0;
    if (reset) return '0;
    for (int k = 0; k < N; k++) begin
      r = (m_ptr + k) % N;
      if (v_valid[r]) begin
        b = model_bank(int'(v_row[r]), int'(v_col[r]), m_bw);
        if (!taken[b]) begin
          taken[b] = 1'b1;
          g[r]     = 1'b1;
        end
      end
    end
    return g;
  endfunction

  task automatic model_clock(input logic [N-1:0] g);
    int b;
    if (reset) begin
      m_ptr = 0; m_bw = 0; m_cnt = 0; m_we = '0;
      for (int k = 0; k < NB; k++) begin
        m_entry[k] = '0;
        m_data[k]  = '0;
      end
    end else begin
      m_we = '0;
      for (int r = 0; r < N; r++) begin
        if (g[r]) begin
          b = model_bank(int'(v_row[r]), int'(v_col[r]), m_bw);
          m_we[b]    = 1'b1;
          m_entry[b] = RW'(int'(v_row[r]) >> m_bw);
          m_data[b]  = v_data[r];
        end
      end
      if ((v_valid & ~g) != '0) begin
        m_ptr = (m_ptr + 1) % N;
        if (m_cnt != 65535) m_cnt++;
      end
      if (cfg_load) m_bw = int'(cfg_bitwidth);
    end
  endtask

  task automatic drive();
    req_valid = v_valid;
    for (int i = 0; i < N; i++) begin
      req_row[i*RW +: RW]    = v_row[i];
      req_column[i*RW +: RW] = v_col[i];
      req_data[i*DW +: DW]   = v_data[i];
    end
  endtask

  task automatic set_req(input int i, input int row, input int col);
    v_valid[i] = 1'b1;
    v_row[i]   = RW'(row);
    v_col[i]   = RW'(col);
    v_data[i]  = DW'($urandom);
  endtask

  // One clock cycle: drive, check combinational grants, clock, check registers.
  task automatic step();
    logic [NB*RW-1:0] exp_entry;
    logic [NB*DW-1:0] exp_data;
    drive();
    #2;
    exp_ready = model_grant();
    obs_ready = req_ready;
    check("req_ready", 512'(obs_ready), 512'(exp_ready));
    check("busy_pre", 512'(busy), 512'((|v_valid) | (|m_we)));
    @(posedge clk);
    model_clock(exp_ready);
    #1;
    for (int k = 0; k < NB; k++) begin
      exp_entry[k*RW +: RW] = m_entry[k];
      exp_data[k*DW +: DW]  = m_data[k];
    end
    check("bank_we", 512'(bank_we), 512'(m_we));
    check("bank_entry", 512'(bank_entry), 512'(exp_entry));
    check("bank_data", 512'(bank_data), 512'(exp_data));
    check("conflict_count", 512'(conflict_count), 512'(m_cnt));
    check("busy_post", 512'(busy), 512'((|v_valid) | (|m_we)));
    v_valid = v_valid & ~exp_ready;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    cfg_load = 1'b0;
    v_valid  = '0;
    step();
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; cfg_load = 1'b0; cfg_bitwidth = '0;
    v_valid = '0;
    for (int i = 0; i < N; i++) begin
      v_row[i] = '0; v_col[i] = '0; v_data[i] = '0;
    end
    m_ptr = 0; m_bw = 0; m_cnt = 0; m_we = '0;
    for (int k = 0; k < NB; k++) begin
      m_entry[k] = '0; m_data[k] = '0;
    end
    drive();
    @(posedge clk);
    #1;

    // Reset held for two cycles with all requesters valid.
    for (int i = 0; i < N; i++) set_req(i, $urandom_range(0, 255), $urandom_range(0, 255));
    repeat (2) begin
      step();
      check("rst_ready", 512'(obs_ready), 512'(0));
      check("rst_we", 512'(bank_we), 512'(0));
      check("rst_cnt", 512'(conflict_count), 512'(0));
    end
    reset = 1'b0;
    for (int t = 0; t < 8 && v_valid != '0; t++) step();
    check("drained", 512'(v_valid), 512'(0));
    step();

    // Distinct banks, bitwidth 0: everything granted at once.
    do_reset();
    set_req(0, 1, 0); set_req(1, 0, 5); set_req(2, 10, 0); set_req(3, 11, 0);
    step();
    check("t2_ready", 512'(obs_ready), 512'(4'b1111));
    check("t2_we", 512'(bank_we), 512'(32'h4000_002A));
    check("t2_entry30", 512'(bank_entry[30*RW +: RW]), 512'(8'd10));
    check("t2_entry1", 512'(bank_entry[1*RW +: RW]), 512'(8'd11));
    check("t2_cnt", 512'(conflict_count), 512'(0));

    // Two requesters colliding on bank 3.
    set_req(0, 1, 0); set_req(1, 0, 3);
    step();
    check("t3_c0_ready", 512'(obs_ready), 512'(4'b0001));
    check("t3_c0_cnt", 512'(conflict_count), 512'(1));
    step();
    check("t3_c1_ready", 512'(obs_ready), 512'(4'b0010));
    check("t3_c1_entry3", 512'(bank_entry[3*RW +: RW]), 512'(8'd0));
    check("t3_c1_data3", 512'(bank_data[3*DW +: DW]), 512'(v_data[1]));

    // Bitwidth load: same-cycle request uses the old mapping, next one the new.
    cfg_load = 1'b1; cfg_bitwidth = 2'd1;
    set_req(0, 5, 12);
    step();
    check("t4_old_we", 512'(bank_we), 512'(32'h0800_0000));
    check("t4_old_entry", 512'(bank_entry[27*RW +: RW]), 512'(8'd5));
    cfg_load = 1'b0;
    set_req(0, 5, 12);
    step();
    check("t4_new_we", 512'(bank_we), 512'(32'h0000_0004));
    check("t4_new_entry", 512'(bank_entry[2*RW +: RW]), 512'(8'd2));
    cfg_load = 1'b1; cfg_bitwidth = 2'd0;
    step();
    cfg_load = 1'b0;

    // Fairness: all four on bank 7, served in order 0..3.
    do_reset();
    set_req(0, 0, 7); set_req(1, 1, 4); set_req(2, 2, 1); set_req(3, 3, 30);
    for (int k = 0; k < N; k++) begin
      step();
      check("t5_order", 512'(obs_ready), 512'(1 << k));
    end
    check("t5_cnt", 512'(conflict_count), 512'(3));

    // Reset in the cycle after a grant drops the pending write and the pointer.
    do_reset();
    set_req(0, 1, 0); set_req(1, 0, 3);
    step();
    reset = 1'b1;
    step();
    check("t6_we", 512'(bank_we), 512'(0));
    check("t6_cnt", 512'(conflict_count), 512'(0));
    reset = 1'b0;
    set_req(0, 1, 0);
    step();
    check("t6_ptr0", 512'(obs_ready), 512'(4'b0001));
    while (v_valid != '0) step();

    // Random traffic, biased towards small coordinates to force collisions.
    for (int t = 0; t < 400; t++) begin
      reset = ($urandom_range(0, 149) == 0);
      if (v_valid == '0 && m_we == '0 && $urandom_range(0, 9) == 0) begin
        cfg_load     = 1'b1;
        cfg_bitwidth = 2'($urandom_range(0, 3));
      end else begin
        cfg_load = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
        if (!v_valid[i] && $urandom_range(0, 1) == 1) begin
          if ($urandom_range(0, 3) != 0)
            set_req(i, $urandom_range(0, 15), $urandom_range(0, 15));
          else
            set_req(i, $urandom_range(0, 255), $urandom_range(0, 255));
        end
      end
      step();
    end
    reset = 1'b0;
    cfg_load = 1'b0;

    // Saturation: permanent contention on one bank for more than 2^16 cycles.
    do_reset();
    set_req(0, 0, 7); set_req(1, 1, 4); set_req(2, 2, 1); set_req(3, 3, 30);
    drive();
    repeat (65540) @(posedge clk);
    #1;
    check("saturate", 512'(conflict_count), 512'(16'hFFFF));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
